// File: rtl/lidar_scan_processor.sv
// Parses framed LiDAR scan packets from a UART byte stream and reports
// min/max distance with indices plus a per-sector obstacle bitmask.
module lidar_scan_processor #(
  parameter int          DIST_W       = 16,
  parameter int          MAX_SAMPLES  = 64,
  parameter int          NUM_SECTORS  = 8,
  parameter int          SECTOR_SHIFT = 3,
  parameter logic [7:0]  HDR0         = 8'hAA,
  parameter logic [7:0]  HDR1         = 8'h55,
  parameter int          TIMEOUT_CYC  = 100000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_dv,
  input  logic [7:0]             rx_byte,
  input  logic [DIST_W-1:0]      threshold,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             ct,
  output logic [15:0]            fsa,
  output logic [15:0]            lsa,
  output logic [DIST_W-1:0]      min_dist,
  output logic [7:0]             min_idx,
  output logic [DIST_W-1:0]      max_dist,
  output logic [7:0]             max_idx,
  output logic [NUM_SECTORS-1:0] obs_alert,
  output logic                   pkt_err,
  output logic                   overrun
);

  localparam int BYTES = DIST_W / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    HUNT, HDR, CNT, FSA0, FSA1, LSA0, LSA1, SAMP
  } state_t;

  state_t state_reg, state_next;

  logic [TW-1:0]          tmo_cnt_reg;
  logic [7:0]             ct_reg;
  logic [DIST_W-1:0]      thr_reg;
  logic [15:0]            fsa_reg;
  logic [15:0]            lsa_reg;
  logic [BCW-1:0]         byte_cnt_reg;
  logic [7:0]             samp_idx_reg;
  logic [DIST_W-1:0]      samp_buf_reg;
  logic                   found_reg;
  logic [DIST_W-1:0]      acc_min_reg;
  logic [7:0]             acc_min_idx_reg;
  logic [DIST_W-1:0]      acc_max_reg;
  logic [7:0]             acc_max_idx_reg;
  logic [NUM_SECTORS-1:0] acc_alert_reg;

  logic                   tmo_hit;
  logic                   ct_ok;
  logic                   samp_last_byte;
  logic                   scan_done;
  logic                   cnt_accept;
  logic                   pkt_err_next;

  logic [DIST_W-1:0]      d_full;
  logic                   d_valid;
  logic                   min_upd;
  logic                   max_upd;
  logic [NUM_SECTORS-1:0] alert_set;
  logic [DIST_W-1:0]      min_next;
  logic [7:0]             min_idx_next;
  logic [DIST_W-1:0]      max_next;
  logic [7:0]             max_idx_next;
  logic [NUM_SECTORS-1:0] alert_next;

  assign tmo_hit        = (state_reg != HUNT) && !rx_dv && (tmo_cnt_reg == TW'(TIMEOUT_CYC - 1));
  assign ct_ok          = (rx_byte != 8'd0) && (int'(rx_byte) <= MAX_SAMPLES);
  assign samp_last_byte = (state_reg == SAMP) && rx_dv && (byte_cnt_reg == BCW'(BYTES - 1));
  assign scan_done      = samp_last_byte && (samp_idx_reg == ct_reg - 8'd1);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= HUNT;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    if (tmo_hit) begin
      state_next = HUNT;
    end else if (rx_dv) begin
      case (state_reg)
        HUNT: if (rx_byte == HDR0) state_next = HDR;
        HDR: begin
          if (rx_byte == HDR1)      state_next = CNT;
          else if (rx_byte == HDR0) state_next = HDR;
          else                      state_next = HUNT;
        end
        CNT:     state_next = ct_ok ? FSA0 : HUNT;
        FSA0:    state_next = FSA1;
        FSA1:    state_next = LSA0;
        LSA0:    state_next = LSA1;
        LSA1:    state_next = SAMP;
        SAMP:    state_next = scan_done ? HUNT : SAMP;
        default: state_next = HUNT;
      endcase
    end
  end

  // ---------------- FSM: decoded outputs ----------------
  always_comb begin
    cnt_accept   = 1'b0;
    pkt_err_next = 1'b0;
    if (tmo_hit) begin
      pkt_err_next = 1'b1;
    end else if (state_reg == CNT && rx_dv) begin
      cnt_accept   = ct_ok;
      pkt_err_next = !ct_ok;
    end
  end

  // Sample assembly: the arriving byte drops into its lane, earlier lanes come from the buffer.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      assign d_full[8*gi +: 8] = (int'(byte_cnt_reg) == gi) ? rx_byte : samp_buf_reg[8*gi +: 8];
    end
  endgenerate

  assign d_valid = (d_full != '0);
  assign min_upd = samp_last_byte && d_valid && (!found_reg || d_full < acc_min_reg);
  assign max_upd = samp_last_byte && d_valid && (d_full > acc_max_reg);

  generate
    for (gi = 0; gi < NUM_SECTORS; gi++) begin : g_alert
      assign alert_set[gi] = samp_last_byte && d_valid && (d_full < thr_reg) &&
                             (int'(samp_idx_reg >> SECTOR_SHIFT) == gi);
    end
  endgenerate

  assign min_next     = min_upd ? d_full : acc_min_reg;
  assign min_idx_next = min_upd ? samp_idx_reg : acc_min_idx_reg;
  assign max_next     = max_upd ? d_full : acc_max_reg;
  assign max_idx_next = max_upd ? samp_idx_reg : acc_max_idx_reg;
  assign alert_next   = acc_alert_reg | alert_set;

  // Inter-byte watchdog, only armed while inside a packet
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == HUNT || rx_dv) begin
      tmo_cnt_reg <= '0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ct_reg          <= '0;
      thr_reg         <= '0;
      fsa_reg         <= '0;
      lsa_reg         <= '0;
      byte_cnt_reg    <= '0;
      samp_idx_reg    <= '0;
      samp_buf_reg    <= '0;
      found_reg       <= 1'b0;
      acc_min_reg     <= '0;
      acc_min_idx_reg <= '0;
      acc_max_reg     <= '0;
      acc_max_idx_reg <= '0;
      acc_alert_reg   <= '0;
    end else if (cnt_accept) begin
      ct_reg          <= rx_byte;
      thr_reg         <= threshold;
      byte_cnt_reg    <= '0;
      samp_idx_reg    <= '0;
      samp_buf_reg    <= '0;
      found_reg       <= 1'b0;
      acc_min_reg     <= '0;
      acc_min_idx_reg <= '0;
      acc_max_reg     <= '0;
      acc_max_idx_reg <= '0;
      acc_alert_reg   <= '0;
    end else if (rx_dv && !tmo_hit) begin
      case (state_reg)
        FSA0: fsa_reg[7:0]  <= rx_byte;
        FSA1: fsa_reg[15:8] <= rx_byte;
        LSA0: lsa_reg[7:0]  <= rx_byte;
        LSA1: lsa_reg[15:8] <= rx_byte;
        SAMP: begin
          samp_buf_reg <= d_full;
          if (samp_last_byte) begin
            byte_cnt_reg    <= '0;
            samp_idx_reg    <= samp_idx_reg + 8'd1;
            found_reg       <= found_reg | d_valid;
            acc_min_reg     <= min_next;
            acc_min_idx_reg <= min_idx_next;
            acc_max_reg     <= max_next;
            acc_max_idx_reg <= max_idx_next;
            acc_alert_reg   <= alert_next;
          end else begin
            byte_cnt_reg <= byte_cnt_reg + BCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Result register: loads straight from the accumulator next-values so the
  // result appears on the cycle after the final byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      ct        <= '0;
      fsa       <= '0;
      lsa       <= '0;
      min_dist  <= '0;
      min_idx   <= '0;
      max_dist  <= '0;
      max_idx   <= '0;
      obs_alert <= '0;
      pkt_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      pkt_err <= pkt_err_next;
      overrun <= 1'b0;
      if (scan_done) begin
        if (out_valid && !out_ready) begin
          overrun <= 1'b1;
        end else begin
          out_valid <= 1'b1;
          ct        <= ct_reg;
          fsa       <= fsa_reg;
          lsa       <= lsa_reg;
          min_dist  <= min_next;
          min_idx   <= min_idx_next;
          max_dist  <= max_next;
          max_idx   <= max_idx_next;
          obs_alert <= alert_next;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/lidar_scan_processor.md
Name: lidar_scan_processor

Overview:
Parametrised successor to the fixed-format distance processor. Consumes the byte stream from the UART receiver, parses framed LiDAR scan packets with a configurable sample width and count, and computes min/max distance with sample index plus a per-sector obstacle bitmask. Results go to the transmit path via a valid/ready handshake. Malformed, oversized or stalled packets are dropped and flagged.

Parameters:
DIST_W, 16, distance width in bits; multiple of 8, range 8..32; each sample is DIST_W/8 bytes, little-endian.
MAX_SAMPLES, 64, largest accepted CT, range 1..255.
NUM_SECTORS, 8, number of obstacle-alert sectors.
SECTOR_SHIFT, 3, samples per sector = 2^SECTOR_SHIFT.
HDR0, 8'hAA, first header byte.
HDR1, 8'h55, second header byte.
TIMEOUT_CYC, 100000, maximum clk cycles allowed between bytes inside a packet.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
rx_dv  input  1  one-cycle strobe; rx_byte is valid
rx_byte  input  8  received byte
threshold  input  DIST_W  obstacle threshold; sampled when CT is accepted
out_valid  output  1  result available
out_ready  input  1  consumer accepts the result
ct  output  8  sample count of the reported scan
fsa  output  16  first sample angle
lsa  output  16  last sample angle
min_dist  output  DIST_W  smallest nonzero distance
min_idx  output  8  index of min_dist
max_dist  output  DIST_W  largest distance
max_idx  output  8  index of max_dist
obs_alert  output  NUM_SECTORS  per-sector alert bits
pkt_err  output  1  one-cycle pulse; packet dropped
overrun  output  1  one-cycle pulse; completed result discarded

Behaviour:
- Reset (reset=0, asynchronous): FSM goes to HUNT. All outputs and accumulators go to 0. Release is synchronous to clk.
- Packet format: HDR0, HDR1, CT, FSA_L, FSA_H, LSA_L, LSA_H, then CT samples of DIST_W/8 bytes each, LSB first.
- FSM states: HUNT, HDR, CNT, FSA0, FSA1, LSA0, LSA1, SAMP. Transitions happen only on rx_dv.
- HUNT to HDR: on HDR0.
- HDR: HDR1 goes to CNT. A repeated HDR0 stays in HDR. Any other byte goes to HUNT, with no error.
- CNT: CT=0 or CT>MAX_SAMPLES raises pkt_err and goes to HUNT. Otherwise latch CT and threshold, clear the accumulators, and go to FSA0.
- FSA0, FSA1, LSA0 and LSA1 each latch one byte of the angles.
- SAMP: assemble each sample from its bytes; sample index i runs 0..CT-1.
- Sample update on completion of each sample d:
  - d=0 is invalid and excluded from min, max and alert.
  - Min update: d<min (or first valid sample) sets min_dist=d, min_idx=i.
  - Max update: d>max sets max_dist=d, max_idx=i.
  - Ties keep the earliest index (strict compare).
  - Alert: d<threshold sets alert bit (i>>SECTOR_SHIFT), provided that value is <NUM_SECTORS. Otherwise the sample is ignored for alert.
- Completion: the last byte of sample CT-1 returns the FSM to HUNT. On the next cycle, out_valid=1 and all outputs load from the accumulators (latency 1 cycle after that rx_dv).
- No valid samples: min_dist=max_dist=0 and min_idx=max_idx=0.
- Handshake: outputs are stable while out_valid=1. The result is consumed on out_valid&out_ready, and out_valid drops on the next cycle unless a new result loads in that same cycle; in that case out_valid stays 1 with the new data.
- Parsing continues while out_valid is held. If a scan completes while out_valid=1 and out_ready=0, the new result is discarded, overrun pulses, and the old result is held.
- Timeout: in any state other than HUNT, a counter reset on each rx_dv runs; reaching TIMEOUT_CYC raises pkt_err and goes to HUNT. Partial accumulators never reach the outputs.
- Reset mid-packet or mid-handshake: immediate return to the reset state; any pending result is lost.
- CT, FSA, LSA and threshold of the reported scan come from that scan's own header.

Test Plan:
- Clean packet, DIST_W=16: AA 55 04 10 00 50 00 with samples 0x0200, 0x0050, 0x0300, 0x0050, threshold=0x0100 -> out_valid 1 cycle after last byte; min=0x0050, idx 1; max=0x0300, idx 2; fsa=0x0010; lsa=0x0050; obs_alert=8'h01.
- Zero and sector handling: CT=16 with samples 0 except sample 9 = 0x0020, threshold 0x0040 -> min=max=0x0020, both idx 9; obs_alert=8'h02; zeros ignored.
- Errors: CT=0 -> pkt_err pulse, no out_valid. CT=65 with MAX_SAMPLES=64 -> pkt_err. Bytes stop after FSA0 for TIMEOUT_CYC cycles -> pkt_err, FSM in HUNT; the next clean packet is processed correctly.
- Resync: stream 00 AA AA 55 followed by a valid packet -> result reported. Stream AA 12 -> silent return to HUNT, no error.
- Backpressure: out_ready=0 while two scans complete -> first result held unchanged, overrun pulses once. Raise out_ready -> first result accepted, out_valid=0 next cycle.
- Reset mid-packet: assert reset during SAMP -> all outputs 0 immediately; after release, a following valid packet gives the correct result.
